// File: rtl/stage_if_pkg.sv
// Purpose: shared pc_select encodings, IF FSM state type and NOP word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stage_if_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;   // sequential fetch_pc+4
    localparam logic [1:0] PCSEL_BR  = 2'b01;   // taken branch, pc_b
    localparam logic [1:0] PCSEL_JR  = 2'b10;   // register jump, a_id
    localparam logic [1:0] PCSEL_J   = 2'b11;   // j/jal, pc_j

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } if_state_e;

endpackage

// File: rtl/stage_if_if.sv
// Purpose: instruction memory request/ready handshake between IF and imem.
// Latency: n/a (wires only).
// Backpressure: imem_ready low holds the request; address must stay stable.
// Ports: master (IF) drives imem_req/imem_addr, slave (memory) drives imem_ready/imem_rdata.
interface stage_if_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/stage_if_next_pc.sv
// Purpose: combinational redirect-target mux and next-fetch-PC priority select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; callers decide when next_pc_o is used.
// Ports: pc_select_i/pc_b_i/a_id_i/pc_j_i pick the target; redirect_i and
//        redir_valid_i/redir_pc_i choose between live, pending and sequential PC.
module if_next_pc
    import stage_if_pkg::*;
(
    input  logic [1:0]  pc_select_i,
    input  logic [31:0] pc_b_i,
    input  logic [31:0] pc_j_i,
    input  logic [31:0] a_id_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        redirect_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    output logic [31:0] target_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);

    // 32-bit add wraps naturally: 32'hFFFFFFFC + 4 = 0.
    assign pc_plus4_o = fetch_pc_i + 32'd4;

    always_comb begin
        target_o = pc_j_i;
        case (pc_select_i)
            PCSEL_BR: target_o = pc_b_i;
            PCSEL_JR: target_o = a_id_i;
            PCSEL_J:  target_o = pc_j_i;
            default:  target_o = pc_j_i;
        endcase
    end

    // A redirect seen this cycle wins over one parked from an earlier cycle.
    always_comb begin
        next_pc_o = pc_plus4_o;
        if (redirect_i) begin
            next_pc_o = target_o;
        end else if (redir_valid_i) begin
            next_pc_o = redir_pc_i;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Purpose: MIPS-style instruction fetch stage with delay-slot redirect and 1-entry hold buffer.
// Latency: fetched word reaches the IF/ID register on the edge that completes the fetch.
// Backpressure: ID stall freezes PC and IF/ID; a word returning during stall parks in HOLD.
// Ports: clock/reset_0 (sync active-low), stall, pc_select + pc_b/pc_j/a_id from ID,
//        imem handshake via stage_if_if.master, IF/ID outputs instr_id/pc4_id/id_valid.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset_0,
    input  logic          stall,
    input  logic [1:0]    pc_select,
    input  logic [31:0]   pc_b,
    input  logic [31:0]   pc_j,
    input  logic [31:0]   a_id,
    stage_if_if.master    imem,
    output logic [31:0]   instr_id,
    output logic [31:0]   pc4_id,
    output logic          id_valid
);

    if_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        redirect;
    logic        consume;
    logic [31:0] word;
    logic        imem_req_c;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // Only a valid instruction that is actually leaving ID may redirect.
    assign redirect = !stall && valid_q && (pc_select != PCSEL_SEQ);

    if_next_pc u_next_pc (
        .pc_select_i   (pc_select),
        .pc_b_i        (pc_b),
        .pc_j_i        (pc_j),
        .a_id_i        (a_id),
        .fetch_pc_i    (fetch_pc_q),
        .redirect_i    (redirect),
        .redir_valid_i (redir_valid_q),
        .redir_pc_i    (redir_pc_q),
        .target_o      (target),
        .pc_plus4_o    (pc_plus4),
        .next_pc_o     (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        hold_d        = hold_q;
        instr_d       = instr_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        imem_req_c    = 1'b0;
        consume       = 1'b0;
        word          = hold_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem.imem_ready) begin
                    if (stall) begin
                        hold_d  = imem.imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        consume = 1'b1;
                        word    = imem.imem_rdata;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    consume = 1'b1;
                    word    = hold_q;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (consume) begin
            instr_d       = word;
            pc4_d         = pc_plus4;
            valid_d       = 1'b1;
            fetch_pc_d    = next_pc;
            state_d       = ST_FETCH;
            redir_valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            // No word to carry the redirect yet: park it for the next consume.
            if (redirect) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = target;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_0) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            hold_q        <= NOP_WORD;
            instr_q       <= NOP_WORD;
            pc4_q         <= 32'd0;
            valid_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            hold_q        <= hold_d;
            instr_q       <= instr_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign imem.imem_req  = imem_req_c;
    assign imem.imem_addr = fetch_pc_q;
    assign instr_id       = instr_q;
    assign pc4_id         = pc4_q;
    assign id_valid       = valid_q;

endmodule
